change_dispenser: RTL and testbench

Payout back end of the vending controller. It accepts the one-cycle `out`, `change5` and `change10` pulses that the vending FSM emits. It queues them as pending counts and serializes them onto a product-motor handshake and a coin-hopper handshake, with timeout fault detection. It sits between the vending FSM outputs and the physical actuators.

---
 rtl/change_dispenser_if.sv | 39 +++
 rtl/change_dispenser.sv | 191 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// ---------------------------------------------------------------------------
// change_dispenser_if
// Groups the request pulses, the actuator handshakes and the status flags of
// the change dispenser.
//   slave  : dispenser side (takes requests and done strobes, drives
//            actuators and status)
//   master : vending FSM / actuator / test side
// Signals:
//   out, change5, change10   request pulses (product, 5-coin, 10-coin)
//   prod_motor, prod_done    product-motor level and its completion
//   hopper_fire, hopper_sel  coin-ejection start pulse and coin type
//   hopper_done              coin-ejection completion
//   busy, fault, overflow    status flags
//   fault_clr                leaves FAULT and clears overflow
// ---------------------------------------------------------------------------
interface change_dispenser_if;
    logic out;
    logic change5;
    logic change10;
    logic prod_motor;
    logic prod_done;
    logic hopper_fire;
    logic hopper_sel;
    logic hopper_done;
    logic busy;
    logic fault;
    logic overflow;
    logic fault_clr;

    modport slave (
        input  out, change5, change10, prod_done, hopper_done, fault_clr,
        output prod_motor, hopper_fire, hopper_sel, busy, fault, overflow
    );

    modport master (
        output out, change5, change10, prod_done, hopper_done, fault_clr,
        input  prod_motor, hopper_fire, hopper_sel, busy, fault, overflow
    );
endinterface

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Payout back end of the vending controller. Request pulses are accumulated
// in three saturating pending counters and served one at a time, product
// first, then 10-coins, then 5-coins, over the product-motor and
// coin-hopper handshakes. A wait that exceeds TIMEOUT cycles drops the item
// in flight and parks the block in FAULT until fault_clr.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  change_dispenser_if.slave (requests, handshakes, status)
// Parameters:
//   CNT_W    width of each pending counter (saturates at 2^CNT_W-1)
//   TIMEOUT  wait cycles allowed for a done strobe, 1..65535
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [15:0]      TMO      = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PROD_WAIT = 3'd1,
        ST_HOP_FIRE  = 3'd2,
        ST_HOP_WAIT  = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] c10_cnt_q, c10_cnt_d;
    logic [CNT_W-1:0] c5_cnt_q, c5_cnt_d;
    logic             dec_p_s, dec_c10_s, dec_c5_s;
    logic             ovf_set_s;
    logic             prod_motor_q, prod_motor_d;
    logic             hopper_fire_q, hopper_fire_d;
    logic             hopper_sel_q, hopper_sel_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;
    logic             overflow_q, overflow_d;

    // A saturated counter drops the request; a dispatch decrement is applied
    // afterwards, so increment plus decrement leaves the count unchanged.
    function automatic logic [CNT_W-1:0] next_cnt(
        input logic [CNT_W-1:0] cnt,
        input logic             req,
        input logic             dec
    );
        logic [CNT_W-1:0] r;
        r = cnt;
        if (req && (cnt != CNT_MAX)) begin
            r = r + CNT_ONE;
        end else begin
            r = r;
        end
        if (dec) begin
            r = r - CNT_ONE;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Next-state, dispatch and wait-counter logic of the payout FSM.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        hopper_sel_d = hopper_sel_q;
        dec_p_s      = 1'b0;
        dec_c10_s    = 1'b0;
        dec_c5_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (p_cnt_q != CNT_ZERO) begin
                    dec_p_s    = 1'b1;
                    wait_cnt_d = 16'd0;
                    state_d    = ST_PROD_WAIT;
                end else if (c10_cnt_q != CNT_ZERO) begin
                    dec_c10_s    = 1'b1;
                    hopper_sel_d = 1'b1;
                    state_d      = ST_HOP_FIRE;
                end else if (c5_cnt_q != CNT_ZERO) begin
                    dec_c5_s     = 1'b1;
                    hopper_sel_d = 1'b0;
                    state_d      = ST_HOP_FIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROD_WAIT: begin
                // Done wins over a timeout detected in the same cycle.
                if (bus.prod_done) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == TMO) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_HOP_FIRE: begin
                wait_cnt_d = 16'd0;
                state_d    = ST_HOP_WAIT;
            end
            ST_HOP_WAIT: begin
                if (bus.hopper_done) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == TMO) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending counters, overflow flag and the registered output values.
    always_comb begin
        p_cnt_d   = next_cnt(p_cnt_q,   bus.out,      dec_p_s);
        c10_cnt_d = next_cnt(c10_cnt_q, bus.change10, dec_c10_s);
        c5_cnt_d  = next_cnt(c5_cnt_q,  bus.change5,  dec_c5_s);
        ovf_set_s = (bus.out      && (p_cnt_q   == CNT_MAX)) ||
                    (bus.change10 && (c10_cnt_q == CNT_MAX)) ||
                    (bus.change5  && (c5_cnt_q  == CNT_MAX));
        overflow_d    = ovf_set_s || (overflow_q && !bus.fault_clr);
        prod_motor_d  = (state_d == ST_PROD_WAIT);
        hopper_fire_d = (state_d == ST_HOP_FIRE);
        fault_d       = (state_d == ST_FAULT);
        // Looking at both the current and next state keeps busy high through
        // the IDLE cycle that follows a completed item.
        busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE) ||
                 (p_cnt_d != CNT_ZERO) || (c10_cnt_d != CNT_ZERO) ||
                 (c5_cnt_d != CNT_ZERO);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 16'd0;
            p_cnt_q       <= CNT_ZERO;
            c10_cnt_q     <= CNT_ZERO;
            c5_cnt_q      <= CNT_ZERO;
            prod_motor_q  <= 1'b0;
            hopper_fire_q <= 1'b0;
            hopper_sel_q  <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            p_cnt_q       <= p_cnt_d;
            c10_cnt_q     <= c10_cnt_d;
            c5_cnt_q      <= c5_cnt_d;
            prod_motor_q  <= prod_motor_d;
            hopper_fire_q <= hopper_fire_d;
            hopper_sel_q  <= hopper_sel_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.prod_motor  = prod_motor_q;
    assign bus.hopper_fire = hopper_fire_q;
    assign bus.hopper_sel  = hopper_sel_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if ifa ();
    change_dispenser_if ifb ();

    change_dispenser #(.CNT_W(3), .TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    change_dispenser #(.CNT_W(3), .TIMEOUT(4))   dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model thinks in jobs: what is being served and how many cycles ago
    // it was started. Outputs follow directly from that.
    localparam int J_NONE  = 0;
    localparam int J_PROD  = 1;
    localparam int J_COIN  = 2;
    localparam int J_FAULT = 3;
    localparam int MAXC    = 7;

    typedef struct {
        int p; int c10; int c5;
        int job; int age;
        bit sel; bit ovf; bit busy;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t mreset();
        mst_t r;
        r.p = 0; r.c10 = 0; r.c5 = 0; r.job = J_NONE; r.age = 0;
        r.sel = 1'b0; r.ovf = 1'b0; r.busy = 1'b0;
        return r;
    endfunction

    function automatic mst_t step(mst_t s, bit o, bit c10, bit c5, bit pd, bit hd, bit clr, int t);
        mst_t n;
        bit tp, t10, t5;
        n = s; tp = 1'b0; t10 = 1'b0; t5 = 1'b0;
        if (s.job == J_NONE) begin
            if (s.p > 0) begin tp = 1'b1; n.job = J_PROD; n.age = 0; end
            else if (s.c10 > 0) begin t10 = 1'b1; n.job = J_COIN; n.sel = 1'b1; n.age = 0; end
            else if (s.c5 > 0) begin t5 = 1'b1; n.job = J_COIN; n.sel = 1'b0; n.age = 0; end
        end else if (s.job == J_PROD) begin
            // age = completed wait cycles; timed out once t have elapsed
            if (pd) n.job = J_NONE;
            else if (s.age == t) n.job = J_FAULT;
            else n.age = s.age + 1;
        end else if (s.job == J_COIN) begin
            // age 0 is the fire cycle; waiting starts one cycle later
            if (s.age == 0) n.age = 1;
            else if (hd) n.job = J_NONE;
            else if (s.age - 1 == t) n.job = J_FAULT;
            else n.age = s.age + 1;
        end else begin
            if (clr) n.job = J_NONE;
        end
        n.ovf = s.ovf && !clr;
        if (o)   begin if (s.p   == MAXC) n.ovf = 1'b1; else n.p   = s.p + 1;   end
        if (c10) begin if (s.c10 == MAXC) n.ovf = 1'b1; else n.c10 = s.c10 + 1; end
        if (c5)  begin if (s.c5  == MAXC) n.ovf = 1'b1; else n.c5  = s.c5 + 1;  end
        if (tp)  n.p   = n.p - 1;
        if (t10) n.c10 = n.c10 - 1;
        if (t5)  n.c5  = n.c5 - 1;
        n.busy = (s.job != J_NONE) || (n.job != J_NONE) || (n.p + n.c10 + n.c5 > 0);
        return n;
    endfunction

    // Model state advance, reset asynchronously like the design.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= step(ma, ifa.out, ifa.change10, ifa.change5, ifa.prod_done,
                       ifa.hopper_done, ifa.fault_clr, 255);
            mb <= step(mb, ifb.out, ifb.change10, ifb.change5, ifb.prod_done,
                       ifb.hopper_done, ifb.fault_clr, 4);
        end
    end

    // Cycle-by-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        check("a_prod_motor",  int'(ifa.prod_motor),  int'(ma.job == J_PROD));
        check("a_hopper_fire", int'(ifa.hopper_fire), int'(ma.job == J_COIN && ma.age == 0));
        check("a_hopper_sel",  int'(ifa.hopper_sel),  int'(ma.sel));
        check("a_busy",        int'(ifa.busy),        int'(ma.busy));
        check("a_fault",       int'(ifa.fault),       int'(ma.job == J_FAULT));
        check("a_overflow",    int'(ifa.overflow),    int'(ma.ovf));
        check("b_prod_motor",  int'(ifb.prod_motor),  int'(mb.job == J_PROD));
        check("b_hopper_fire", int'(ifb.hopper_fire), int'(mb.job == J_COIN && mb.age == 0));
        check("b_hopper_sel",  int'(ifb.hopper_sel),  int'(mb.sel));
        check("b_busy",        int'(ifb.busy),        int'(mb.busy));
        check("b_fault",       int'(ifb.fault),       int'(mb.job == J_FAULT));
        check("b_overflow",    int'(ifb.overflow),    int'(mb.ovf));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.out = 1'b0; ifa.change5 = 1'b0; ifa.change10 = 1'b0;
        ifa.prod_done = 1'b0; ifa.hopper_done = 1'b0; ifa.fault_clr = 1'b0;
        ifb.out = 1'b0; ifb.change5 = 1'b0; ifb.change10 = 1'b0;
        ifb.prod_done = 1'b0; ifb.hopper_done = 1'b0; ifb.fault_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, fires, wide, norder, pstart, hstart, guard, idle_bad;
        int order [4];
        bit prev_pm, prev_hf;

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_prod_motor", int'(ifa.prod_motor), 0);
        check("rst_fault", int'(ifb.fault), 0);

        // 1: single product, done 5 cycles after motor start
        tick(); ifa.out = 1'b1; tick(); ifa.out = 1'b0;
        check("t1_busy_rise", int'(ifa.busy), 1);
        check("t1_pm_not_yet", int'(ifa.prod_motor), 0);
        tick();
        cnt = 0; fires = 0;
        if (ifa.prod_motor) cnt++;
        repeat (4) begin
            tick();
            if (ifa.prod_motor) cnt++;
            if (ifa.hopper_fire) fires++;
        end
        ifa.prod_done = 1'b1; tick(); ifa.prod_done = 1'b0;
        check("t1_pm_cycles", cnt, 5);
        check("t1_pm_fall", int'(ifa.prod_motor), 0);
        check("t1_busy_lag", int'(ifa.busy), 1);
        tick();
        check("t1_busy_fall", int'(ifa.busy), 0);
        check("t1_no_fire", fires + int'(ifa.hopper_fire), 0);

        // 2: all three requests in one cycle, done 2 cycles after each start
        tick();
        ifa.out = 1'b1; ifa.change10 = 1'b1; ifa.change5 = 1'b1;
        tick();
        ifa.out = 1'b0; ifa.change10 = 1'b0; ifa.change5 = 1'b0;
        fires = 0; wide = 0; norder = 0; pstart = -10; hstart = -10;
        prev_pm = 1'b0; prev_hf = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            ifa.prod_done = 1'b0; ifa.hopper_done = 1'b0;
            if (ifa.prod_motor && !prev_pm) begin
                if (norder < 4) order[norder] = 1;
                norder++; pstart = cyc;
            end
            if (ifa.hopper_fire) begin
                if (prev_hf) wide++;
                else begin
                    if (norder < 4) order[norder] = ifa.hopper_sel ? 2 : 3;
                    norder++;
                end
                fires++; hstart = cyc;
            end
            if (ifa.prod_motor && cyc == pstart + 1) ifa.prod_done = 1'b1;
            if (cyc == hstart + 1) ifa.hopper_done = 1'b1;
            prev_pm = ifa.prod_motor; prev_hf = ifa.hopper_fire;
        end
        ifa.prod_done = 1'b0; ifa.hopper_done = 1'b0;
        check("t2_events", norder, 3);
        check("t2_first_prod", order[0], 1);
        check("t2_second_sel1", order[1], 2);
        check("t2_third_sel0", order[2], 3);
        check("t2_fire_count", fires, 2);
        check("t2_fire_width", wide, 0);
        check("t2_idle", int'(ifa.busy), 0);

        // 3: eight back-to-back change5 with hopper stuck, then a ninth
        tick();
        ifa.change5 = 1'b1;
        repeat (8) tick();
        ifa.change5 = 1'b0;
        check("t3_no_overflow", int'(ifa.overflow), 0);
        ifa.change5 = 1'b1; tick(); ifa.change5 = 1'b0;
        check("t3_overflow", int'(ifa.overflow), 1);
        ifa.hopper_done = 1'b1;
        guard = 0; fires = 0;
        while (ifa.busy && guard < 60) begin
            tick(); guard++;
            if (ifa.hopper_fire) fires++;
        end
        ifa.hopper_done = 1'b0;
        check("t3_drained", int'(ifa.busy), 0);
        check("t3_drain_fires", fires, 7);
        check("t3_overflow_sticky", int'(ifa.overflow), 1);
        ifa.fault_clr = 1'b1; tick(); ifa.fault_clr = 1'b0;
        check("t3_overflow_clr", int'(ifa.overflow), 0);
        check("t3_no_fault", int'(ifa.fault), 0);

        // 6: asynchronous reset in PROD_WAIT with two products pending
        tick();
        ifa.out = 1'b1; repeat (3) tick(); ifa.out = 1'b0;
        check("t6_in_prod_wait", int'(ifa.prod_motor), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_pm", int'(ifa.prod_motor), 0);
        check("t6_async_busy", int'(ifa.busy), 0);
        tick();
        rst = 1'b0;
        idle_bad = 0;
        repeat (6) begin
            tick();
            if (ifa.busy || ifa.prod_motor || ifa.hopper_fire) idle_bad++;
        end
        check("t6_no_dispatch", idle_bad, 0);
        ifa.out = 1'b1; tick(); ifa.out = 1'b0; tick();
        check("t6_new_dispatch", int'(ifa.prod_motor), 1);
        ifa.prod_done = 1'b1; tick(); ifa.prod_done = 1'b0; tick();
        check("t6_done_idle", int'(ifa.busy), 0);

        // 4: TIMEOUT=4, hopper never completes
        tick();
        ifb.change10 = 1'b1; tick(); ifb.change10 = 1'b0;
        tick();
        check("t4_fire", int'(ifb.hopper_fire), 1);
        check("t4_sel", int'(ifb.hopper_sel), 1);
        tick();
        repeat (4) tick();
        check("t4_no_fault_yet", int'(ifb.fault), 0);
        tick();
        check("t4_fault", int'(ifb.fault), 1);
        check("t4_fault_fire_low", int'(ifb.hopper_fire), 0);
        repeat (3) tick();
        check("t4_fault_held", int'(ifb.fault), 1);
        ifb.fault_clr = 1'b1; tick(); ifb.fault_clr = 1'b0;
        check("t4_fault_clr", int'(ifb.fault), 0);
        fires = 0;
        repeat (4) begin
            tick();
            if (ifb.hopper_fire) fires++;
        end
        check("t4_not_requeued", fires, 0);
        check("t4_idle", int'(ifb.busy), 0);

        // 5: TIMEOUT=4, prod_done on the timeout cycle
        tick();
        ifb.out = 1'b1; tick(); ifb.out = 1'b0;
        tick();
        check("t5_pm_start", int'(ifb.prod_motor), 1);
        repeat (4) tick();
        check("t5_pm_still", int'(ifb.prod_motor), 1);
        check("t5_no_early_fault", int'(ifb.fault), 0);
        ifb.prod_done = 1'b1; tick(); ifb.prod_done = 1'b0;
        check("t5_pm_done", int'(ifb.prod_motor), 0);
        check("t5_no_fault", int'(ifb.fault), 0);
        repeat (3) tick();
        check("t5_fault_stays0", int'(ifb.fault), 0);
        check("t5_idle", int'(ifb.busy), 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
